mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates a single AXI-lite-style memory port between the Fetch stage's instruction requester (IF) and the load/store data requester (D). One outstanding transaction at a time. Routes each response back to its owner, with registered outputs. Data has priority, but a starvation guard bounds how long Fetch can be locked out. A pipeline flush discards an in-flight fetch response.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width (matches `ADDR_WIDTH)
- DATA_WIDTH, 32, data/instruction width (matches `INST_WIDTH)
- MAX_D_STREAK, 4, consecutive D grants allowed while IF is pending before IF is forced to win

Ports:
- clk  in  1  clock; single clock domain, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_if_req  in  1  fetch request; held with i_if_addr until o_if_gnt
- i_if_addr  in  ADDR_WIDTH  fetch address
- o_if_gnt  out  1  1-cycle pulse: fetch request accepted
- o_if_rdata  out  DATA_WIDTH  instruction; held until next IF response
- o_if_rvld  out  1  1-cycle pulse: o_if_rdata valid
- i_flush  in  1  discard any pending or in-flight fetch
- i_d_req  in  1  data request; held with its fields until o_d_gnt
- i_d_we  in  1  1 = write, 0 = read
- i_d_addr  in  ADDR_WIDTH  data address
- i_d_wdata  in  DATA_WIDTH  write data
- i_d_wstrb  in  DATA_WIDTH/8  byte strobes
- o_d_gnt  out  1  1-cycle pulse: data request accepted
- o_d_rdata  out  DATA_WIDTH  read data; held until next D response
- o_d_rvld  out  1  1-cycle pulse: read data valid or write acknowledged
- o_mem_vld  out  1  address phase valid
- o_mem_addr, o_mem_we, o_mem_wdata, o_mem_wstrb  out  ADDR/1/DATA/DATA/8  latched request fields
- i_mem_rdy  in  1  memory accepts the address phase
- i_mem_rdata  in  DATA_WIDTH  response data
- i_mem_rvld  in  1  response valid (writes also return it)
- o_busy  out  1  state != IDLE

## Operation
State machine: IDLE, ADDR, RESP.

IDLE
- Pick a winner among active requests; IF is eligible only when i_flush = 0.
- D wins by default. IF wins when D is not requesting, or when streak == MAX_D_STREAK and i_if_req = 1.
- On selection: the winner's gnt is asserted combinationally in the same cycle. Owner, address, we, wdata and wstrb are latched; an IF request latches we = 0 and wstrb = 0. Next state is ADDR.

ADDR
- o_mem_vld = 1 and all o_mem_* are driven from the latched fields.
- On i_mem_rdy, go to RESP.

RESP
- On i_mem_rvld, i_mem_rdata is registered into the owner's rdata and the owner's rvld pulses on the next cycle. Next state is IDLE.

General
- i_mem_rvld seen outside RESP is ignored.

Streak counter (width clog2(MAX_D_STREAK+1))
- D grant with i_if_req = 1: increment, saturating at MAX_D_STREAK.
- IF grant: clear to 0.
- D grant with i_if_req = 0: clear to 0.

Flush
- i_flush while owner = IF in ADDR or RESP sets a drop flag.
- The bus transaction still completes, but o_if_rvld and o_if_rdata are not updated. The drop flag clears on return to IDLE.
- i_flush never affects D transactions.

## Timing
- Reset (asynchronous) clears everything: state = IDLE, o_mem_vld = 0, o_mem_addr/wdata/wstrb/we = 0, o_if_gnt = o_d_gnt = 0, o_if_rvld = o_d_rvld = 0, o_if_rdata = o_d_rdata = 0, streak = 0, drop = 0, o_busy = 0.
- Reset mid-transaction abandons the transaction; no rvld is ever produced for it.
- Latency with zero-wait memory (i_mem_rdy = 1 in ADDR, i_mem_rvld on the first RESP cycle):
  - gnt in cycle T; o_mem_vld in T+1; response in T+2; rvld in T+3.
  - A new grant can occur in T+3, giving a minimum of 3 cycles per transaction.
- If i_mem_rdy stays low, o_mem_* stay stable indefinitely; there is no timeout.
- gnt is combinational from req in IDLE. Requesters must deassert req, or present a new request, in the cycle after gnt.
- i_flush in the same IDLE cycle as i_if_req: no IF grant; D may still be granted.

## Test plan
- Single IF read: i_if_req = 1 with addr 0x0000_0000, memory returns 0x0000_0013 with zero wait → o_if_gnt at T, o_mem_addr = 0 at T+1, o_if_rvld with o_if_rdata = 0x0000_0013 at T+3, o_busy low at T+3.
- Simultaneous requests: IF at 0x4 and D read at 0x100 in the same IDLE cycle → D granted first and o_d_rvld returns its data; IF granted next; the two responses are never swapped.
- Starvation guard: D requests continuously and IF requests continuously, MAX_D_STREAK = 4 → grant order D, D, D, D, IF, D…
- Write: D we = 1, addr 0x200, wdata 0xDEADBEEF, wstrb 0xF → o_mem_we = 1 with the fields exact; ack produces o_d_rvld and o_d_rdata is unchanged.
- Flush: i_flush during RESP of an IF read → bus completes, o_if_rvld stays 0 and o_if_rdata keeps its old value; the next IF read delivers normally.
- Backpressure and reset: i_mem_rdy held low for 5 cycles → o_mem_* stable throughout; assert rst_n = 0 in RESP → all outputs 0 immediately, and a later i_mem_rvld produces no rvld.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters,
// data first with a streak guard so fetch cannot starve, one transaction at a time.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_if_req,
  input  logic [ADDR_WIDTH-1:0]   i_if_addr,
  output logic                    o_if_gnt,
  output logic [DATA_WIDTH-1:0]   o_if_rdata,
  output logic                    o_if_rvld,
  input  logic                    i_flush,
  input  logic                    i_d_req,
  input  logic                    i_d_we,
  input  logic [ADDR_WIDTH-1:0]   i_d_addr,
  input  logic [DATA_WIDTH-1:0]   i_d_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_d_wstrb,
  output logic                    o_d_gnt,
  output logic [DATA_WIDTH-1:0]   o_d_rdata,
  output logic                    o_d_rvld,
  output logic                    o_mem_vld,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic                    o_mem_we,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  output logic [DATA_WIDTH/8-1:0] o_mem_wstrb,
  input  logic                    i_mem_rdy,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
  input  logic                    i_mem_rvld,
  output logic                    o_busy
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;
  state_t state, state_nx;
  logic [SW-1:0] streak;
  logic owner_if, drop, drop_now, if_ok, if_win, d_win;
  always_comb begin
    if_ok    = i_if_req && !i_flush;
    d_win    = i_d_req && !(if_ok && streak == SW'(MAX_D_STREAK));
    if_win   = if_ok && !d_win;
    o_d_gnt  = rst_n && state == IDLE && d_win;
    o_if_gnt = rst_n && state == IDLE && if_win;
    drop_now = drop || i_flush;
    state_nx = state == IDLE ? ((d_win || if_win) ? ADDR : IDLE) :
               state == ADDR ? (i_mem_rdy ? RESP : ADDR) :
                               (i_mem_rvld ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_if    <= 1'b0;
      drop        <= 1'b0;
      streak      <= '0;
      o_mem_addr  <= '0;
      o_mem_we    <= 1'b0;
      o_mem_wdata <= '0;
      o_mem_wstrb <= '0;
      o_if_rvld   <= 1'b0;
      o_if_rdata  <= '0;
      o_d_rvld    <= 1'b0;
      o_d_rdata   <= '0;
    end else begin
      o_if_rvld <= 1'b0;
      o_d_rvld  <= 1'b0;
      if (o_d_gnt || o_if_gnt) begin
        owner_if    <= o_if_gnt;
        o_mem_addr  <= o_if_gnt ? i_if_addr : i_d_addr;
        o_mem_we    <= o_d_gnt && i_d_we;
        o_mem_wdata <= o_d_gnt ? i_d_wdata : '0;
        o_mem_wstrb <= o_d_gnt ? i_d_wstrb : '0;
        streak      <= !(o_d_gnt && i_if_req) ? '0 :
                       streak == SW'(MAX_D_STREAK) ? streak : streak + SW'(1);
      end
      if (state != IDLE && owner_if && i_flush) drop <= 1'b1;
      if (state == RESP && i_mem_rvld) begin
        drop <= 1'b0;
        if (owner_if) begin
          o_if_rvld <= !drop_now;
          if (!drop_now) o_if_rdata <= i_mem_rdata;
        end else begin
          o_d_rvld <= 1'b1;
          if (!o_mem_we) o_d_rdata <= i_mem_rdata;
        end
      end
    end
  end
  assign o_mem_vld = state == ADDR;
  assign o_busy    = state != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration order, routing, flush, backpressure and reset.
module tb_mem_port_arbiter;
  logic clk = 0, rst_n = 0;
  logic i_if_req = 0, i_flush = 0, i_d_req = 0, i_d_we = 0, i_mem_rdy = 0, i_mem_rvld = 0;
  logic [31:0] i_if_addr = 0, i_d_addr = 0, i_d_wdata = 0, i_mem_rdata = 0;
  logic [3:0] i_d_wstrb = 0;
  logic o_if_gnt, o_if_rvld, o_d_gnt, o_d_rvld, o_mem_vld, o_mem_we, o_busy;
  logic [31:0] o_if_rdata, o_d_rdata, o_mem_addr, o_mem_wdata;
  logic [3:0] o_mem_wstrb;
  int n = 0, errs = 0;
  logic [5:0] exp_if = 6'b010000;
  always #5 clk = ~clk;
  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rdata(o_if_rdata), .o_if_rvld(o_if_rvld), .i_flush(i_flush), .i_d_req(i_d_req),
    .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata), .i_d_wstrb(i_d_wstrb),
    .o_d_gnt(o_d_gnt), .o_d_rdata(o_d_rdata), .o_d_rvld(o_d_rvld), .o_mem_vld(o_mem_vld),
    .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
    .o_mem_wstrb(o_mem_wstrb), .i_mem_rdy(i_mem_rdy), .i_mem_rdata(i_mem_rdata),
    .i_mem_rvld(i_mem_rvld), .o_busy(o_busy)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic serve(input logic [31:0] d);
    i_mem_rdy = 1;
    tick;
    i_mem_rdy = 0;
    i_mem_rvld = 1;
    i_mem_rdata = d;
    tick;
    i_mem_rvld = 0;
  endtask
  initial begin
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_mem_vld", o_mem_vld, 0);
    chk("rst_rdata", {o_if_rdata, o_d_rdata}, 0);
    chk("rst_gnt", {o_if_gnt, o_d_gnt, o_if_rvld, o_d_rvld}, 0);
    tick;
    tick;
    rst_n = 1;
    tick;
    i_if_req = 1;
    i_if_addr = 0;
    #1;
    chk("if1_gnt", {o_if_gnt, o_d_gnt}, 2'b10);
    tick;
    i_if_req = 0;
    chk("if1_mem", {o_mem_vld, o_mem_we, o_busy}, 3'b101);
    chk("if1_addr", o_mem_addr, 0);
    serve(32'h13);
    chk("if1_rvld", {o_if_rvld, o_d_rvld, o_busy}, 3'b100);
    chk("if1_rdata", o_if_rdata, 32'h13);
    tick;
    chk("if1_pulse", o_if_rvld, 0);
    i_if_req = 1;
    i_if_addr = 32'h4;
    i_d_req = 1;
    i_d_addr = 32'h100;
    #1;
    chk("sim_gnt_d", {o_if_gnt, o_d_gnt}, 2'b01);
    tick;
    i_d_req = 0;
    chk("sim_addr_d", o_mem_addr, 32'h100);
    chk("sim_no_gnt", o_if_gnt, 0);
    serve(32'hAAAA);
    chk("sim_d_rvld", {o_if_rvld, o_d_rvld}, 2'b01);
    chk("sim_d_rdata", o_d_rdata, 32'hAAAA);
    chk("sim_gnt_if", {o_if_gnt, o_d_gnt}, 2'b10);
    tick;
    i_if_req = 0;
    chk("sim_addr_if", o_mem_addr, 32'h4);
    serve(32'h5555);
    chk("sim_if_rvld", {o_if_rvld, o_d_rvld}, 2'b10);
    chk("sim_routing", {o_if_rdata, o_d_rdata}, {32'h5555, 32'hAAAA});
    i_if_req = 1;
    i_d_req = 1;
    i_if_addr = 32'h8;
    i_d_addr = 32'h180;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("streak_gnt%0d", k), {o_if_gnt, o_d_gnt}, {exp_if[k], ~exp_if[k]});
      tick;
      serve(32'h100 + k);
      chk($sformatf("streak_rvld%0d", k), {o_if_rvld, o_d_rvld}, {exp_if[k], ~exp_if[k]});
    end
    i_if_req = 0;
    i_d_req = 0;
    chk("streak_if_rdata", o_if_rdata, 32'h104);
    chk("streak_d_rdata", o_d_rdata, 32'h105);
    tick;
    i_d_req = 1;
    i_d_we = 1;
    i_d_addr = 32'h200;
    i_d_wdata = 32'hDEADBEEF;
    i_d_wstrb = 4'hF;
    #1;
    chk("wr_gnt", o_d_gnt, 1);
    tick;
    i_d_req = 0;
    i_d_we = 0;
    chk("wr_fields", {o_mem_vld, o_mem_we, o_mem_wstrb, o_mem_addr}, {2'b11, 4'hF, 32'h200});
    chk("wr_wdata", o_mem_wdata, 32'hDEADBEEF);
    serve(32'h12345678);
    chk("wr_ack", o_d_rvld, 1);
    chk("wr_rdata_kept", o_d_rdata, 32'h105);
    tick;
    i_if_req = 1;
    i_d_req = 1;
    i_flush = 1;
    i_d_addr = 32'h240;
    #1;
    chk("flush_idle_gnt", {o_if_gnt, o_d_gnt}, 2'b01);
    i_d_req = 0;
    #1;
    chk("flush_idle_none", {o_if_gnt, o_d_gnt}, 2'b00);
    i_flush = 0;
    i_if_addr = 32'h8;
    #1;
    chk("flush_if_gnt", o_if_gnt, 1);
    tick;
    i_if_req = 0;
    i_mem_rdy = 1;
    tick;
    i_mem_rdy = 0;
    i_flush = 1;
    chk("flush_resp", {o_busy, o_mem_vld}, 2'b10);
    tick;
    i_flush = 0;
    i_mem_rvld = 1;
    i_mem_rdata = 32'hBAD;
    tick;
    i_mem_rvld = 0;
    chk("flush_dropped", {o_if_rvld, o_busy}, 2'b00);
    chk("flush_rdata_kept", o_if_rdata, 32'h104);
    i_if_req = 1;
    i_if_addr = 32'hC;
    #1;
    chk("flush_next_gnt", o_if_gnt, 1);
    tick;
    i_if_req = 0;
    serve(32'h77);
    chk("flush_next_rvld", o_if_rvld, 1);
    chk("flush_next_rdata", o_if_rdata, 32'h77);
    tick;
    i_d_req = 1;
    i_d_addr = 32'h300;
    #1;
    chk("bp_gnt", o_d_gnt, 1);
    tick;
    i_d_req = 0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_stable%0d", k), {o_mem_vld, o_mem_we, o_mem_addr}, {2'b10, 32'h300});
      tick;
    end
    i_mem_rdy = 1;
    tick;
    i_mem_rdy = 0;
    chk("bp_resp", {o_busy, o_mem_vld}, 2'b10);
    rst_n = 0;
    #1;
    chk("arst_ctrl", {o_busy, o_mem_vld, o_mem_we, o_d_gnt, o_if_gnt, o_d_rvld, o_if_rvld}, 0);
    chk("arst_data", {o_mem_addr, o_d_rdata}, 0);
    chk("arst_if", {o_if_rdata, o_mem_wdata, o_mem_wstrb}, 0);
    tick;
    rst_n = 1;
    i_mem_rvld = 1;
    i_mem_rdata = 32'h99;
    tick;
    i_mem_rvld = 0;
    chk("arst_no_rvld", {o_d_rvld, o_if_rvld, o_busy}, 0);
    chk("arst_rdata", o_d_rdata, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
